// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: serially loads a pattern, runs one capture cycle,
// then unloads the chain into a parallel response register.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response
);

    // state      | meaning
    // S_IDLE     | waiting for start, chain idle
    // S_SHIFT_IN | shifting pattern MSB-first into the chain
    // S_CAPTURE  | one functional capture cycle
    // S_SHIFT_OUT| shifting chain contents into response
    // S_DONE     | single-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [CHAIN_LEN-1:0] r_pat_sr;
    logic [CHAIN_LEN-1:0] w_pat_next;
    logic [CHAIN_LEN-1:0] r_response;
    logic [CHAIN_LEN-1:0] w_resp_next;
    logic                 r_scan_en;
    logic                 w_scan_en_next;
    logic                 w_cnt_last;

    assign w_cnt_last = (r_cnt == LP_CNT_LAST);

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pat_sr   <= '0;
            r_response <= '0;
            r_scan_en  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt_next;
            r_pat_sr   <= w_pat_next;
            r_response <= w_resp_next;
            r_scan_en  <= w_scan_en_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_pat_next   = r_pat_sr;
        w_resp_next  = r_response;

        // abort wins over start and over any shift/advance on this edge
        if (abort) begin
            w_next_state = S_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_pat_next   = pattern;
                        w_cnt_next   = '0;
                        w_next_state = S_SHIFT_IN;
                    end
                end
                S_SHIFT_IN: begin
                    w_pat_next = {r_pat_sr[CHAIN_LEN-2:0], 1'b0};
                    if (w_cnt_last) begin
                        w_cnt_next   = '0;
                        w_next_state = S_CAPTURE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    w_next_state = S_SHIFT_OUT;
                end
                S_SHIFT_OUT: begin
                    w_resp_next = {r_response[CHAIN_LEN-2:0], scan_out};
                    if (w_cnt_last) begin
                        w_cnt_next   = '0;
                        w_next_state = S_DONE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // scan_en is registered from the next state so it lines up with the shift phases
    assign w_scan_en_next = (w_next_state == S_SHIFT_IN) || (w_next_state == S_SHIFT_OUT);

    assign scan_en  = r_scan_en;
    assign scan_in  = (r_state == S_SHIFT_IN) ? r_pat_sr[CHAIN_LEN-1] : 1'b0;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign response = r_response;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: behavioural scan chains around three DUT sizes,
// expected responses queued by stimulus and checked when done pulses.
module tb_scan_chain_ctrl;

    logic CK  = 1'b0;
    logic RST = 1'b1;
    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- N = 8 instance ----------------
    logic       start8 = 1'b0, abort8 = 1'b0;
    logic [7:0] pattern8 = '0;
    logic       scan_out8, scan_en8, scan_in8, busy8, done8;
    logic [7:0] response8;
    logic [7:0] q8;
    logic       func_mode = 1'b0;
    logic [7:0] func_val  = '0;

    scan_chain_ctrl #(.CHAIN_LEN(8), .CNT_W(4)) u_dut8 (
        .CK(CK), .RST(RST), .start(start8), .abort(abort8), .pattern(pattern8),
        .scan_out(scan_out8), .scan_en(scan_en8), .scan_in(scan_in8),
        .busy(busy8), .done(done8), .response(response8)
    );

    always @(posedge CK or posedge RST)
        if (RST) q8 <= '0;
        else     q8 <= scan_en8 ? {q8[6:0], scan_in8} : (func_mode ? func_val : q8);
    assign scan_out8 = q8[7];

    typedef struct {
        logic [14:0] resp;
        int          cyc;
    } exp_t;

    exp_t q8_exp[$];
    exp_t e8;
    int   done_cnt8 = 0;

    always @(negedge CK) begin
        if (!RST && done8) begin
            done_cnt8++;
            if (q8_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done8 actual=1 expected=0 at cyc=%0d", cyc);
            end else begin
                e8 = q8_exp.pop_front();
                check("response8", 32'(response8), 32'(e8.resp[7:0]));
                check("done_cycle8", cyc, e8.cyc);
            end
        end
    end

    // busy run / idle gap monitor, enabled only during the back-to-back test
    int   run_len = 0, gap_len = 0;
    bit   runs_on = 1'b0;
    logic busy_prev = 1'b0;
    always @(negedge CK) begin
        if (busy8) begin
            if (!busy_prev && runs_on) check("idle_gap", gap_len, 1);
            run_len++;
            gap_len = 0;
        end else begin
            if (busy_prev && runs_on) check("busy_len", run_len, 18);
            run_len = 0;
            gap_len++;
        end
        busy_prev = busy8;
    end

    // ---------------- N = 2 and N = 15 instances ----------------
    logic        start2 = 1'b0;
    logic [1:0]  pattern2 = '0;
    logic        scan_out2, scan_en2, scan_in2, busy2, done2;
    logic [1:0]  response2, q2;
    logic        start15 = 1'b0;
    logic [14:0] pattern15 = '0;
    logic        scan_out15, scan_en15, scan_in15, busy15, done15;
    logic [14:0] response15, q15;
    logic        abort_off = 1'b0;

    scan_chain_ctrl #(.CHAIN_LEN(2), .CNT_W(4)) u_dut2 (
        .CK(CK), .RST(RST), .start(start2), .abort(abort_off), .pattern(pattern2),
        .scan_out(scan_out2), .scan_en(scan_en2), .scan_in(scan_in2),
        .busy(busy2), .done(done2), .response(response2)
    );

    scan_chain_ctrl #(.CHAIN_LEN(15), .CNT_W(4)) u_dut15 (
        .CK(CK), .RST(RST), .start(start15), .abort(abort_off), .pattern(pattern15),
        .scan_out(scan_out15), .scan_en(scan_en15), .scan_in(scan_in15),
        .busy(busy15), .done(done15), .response(response15)
    );

    always @(posedge CK or posedge RST)
        if (RST) q2 <= '0;
        else if (scan_en2) q2 <= {q2[0], scan_in2};
    assign scan_out2 = q2[1];

    always @(posedge CK or posedge RST)
        if (RST) q15 <= '0;
        else if (scan_en15) q15 <= {q15[13:0], scan_in15};
    assign scan_out15 = q15[14];

    logic [14:0] q2_exp[$];
    logic [14:0] q15_exp[$];
    logic [14:0] e_sw;

    always @(negedge CK) begin
        if (!RST && done2) begin
            if (q2_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done2 actual=1 expected=0");
            end else begin
                e_sw = q2_exp.pop_front();
                check("response2", 32'(response2), 32'(e_sw[1:0]));
            end
        end
        if (!RST && done15) begin
            if (q15_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done15 actual=1 expected=0");
            end else begin
                e_sw = q15_exp.pop_front();
                check("response15", 32'(response15), 32'(e_sw));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [17:0] en_v, si_v;
    // bit i = cycle i after the start edge: 8 shift-in, capture, 8 shift-out, done
    localparam logic [17:0] EN_EXP = 18'b011111111011111111;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic run8(input logic [7:0] pat, input logic fmode, input logic [7:0] fval,
                        input logic [7:0] exp_resp);
        exp_t e;
        pattern8  = pat;
        func_mode = fmode;
        func_val  = fval;
        start8    = 1'b1;
        e.resp    = 15'(exp_resp);
        e.cyc     = cyc + 1 + 17;
        q8_exp.push_back(e);
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge CK);
            en_v[i] = scan_en8;
            si_v[i] = scan_in8;
        end
        repeat (3) tick();
    endtask

    int c0;
    int snap;
    int rel;

    initial begin
        repeat (2) @(posedge CK);
        #1;
        check("rst_scan_en", 32'(scan_en8), 0);
        check("rst_scan_in", 32'(scan_in8), 0);
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_response", 32'(response8), 0);
        RST = 1'b0;
        repeat (2) tick();

        // loopback A5
        run8(8'hA5, 1'b0, 8'h00, 8'hA5);
        check("a5_scan_en_seq", 32'(en_v), 32'(EN_EXP));
        check("a5_scan_in_seq", 32'(si_v), 32'h000A5);

        // reset asserted in the fourth SHIFT_IN cycle
        pattern8 = 8'h3C;
        start8   = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        #1;
        check("midrst_scan_en", 32'(scan_en8), 0);
        check("midrst_busy", 32'(busy8), 0);
        check("midrst_response", 32'(response8), 0);
        snap = done_cnt8;
        tick();
        RST = 1'b0;
        repeat (30) tick();
        check("midrst_no_done", done_cnt8, snap);

        // capture of fixed functional data
        run8(8'hFF, 1'b1, 8'h3C, 8'h3C);
        check("cap_scan_en_seq", 32'(en_v), 32'(EN_EXP));
        check("cap_scan_in_seq", 32'(si_v), 32'h000FF);
        func_mode = 1'b0;

        // start held high: three back-to-back tests, start edges 19 apart
        pattern8 = 8'h0F;
        start8   = 1'b1;
        c0       = cyc + 1;
        q8_exp.push_back('{resp: 15'h0F, cyc: c0 + 17});
        q8_exp.push_back('{resp: 15'h0F, cyc: c0 + 36});
        q8_exp.push_back('{resp: 15'h0F, cyc: c0 + 55});
        tick();
        tick();
        runs_on = 1'b1;
        while (cyc < c0 + 64) begin
            tick();
            rel = (cyc - c0) % 19;
            if (rel == 3)  pattern8 = 8'($urandom_range(0, 255));
            if (rel == 12) pattern8 = 8'h0F;
            if (cyc >= c0 + 40) start8 = 1'b0;
        end
        runs_on = 1'b0;
        repeat (3) tick();

        // abort in SHIFT_OUT (cycle 12 after start edge)
        snap     = done_cnt8;
        pattern8 = 8'h5A;
        start8   = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (12) tick();
        abort8 = 1'b1;
        tick();
        abort8 = 1'b0;
        check("abort_busy", 32'(busy8), 0);
        check("abort_scan_en", 32'(scan_en8), 0);
        repeat (20) tick();
        check("abort_no_done", done_cnt8, snap);
        run8(8'hC3, 1'b0, 8'h00, 8'hC3);
        check("post_abort_scan_in_seq", 32'(si_v), 32'h000C3);

        // parameter sweep with random loopback patterns
        for (int k = 0; k < 4; k++) begin
            pattern2 = 2'($urandom_range(0, 3));
            q2_exp.push_back(15'(pattern2));
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            repeat (8) tick();
        end
        for (int k = 0; k < 4; k++) begin
            pattern15 = 15'($urandom_range(0, 32767));
            q15_exp.push_back(pattern15);
            start15 = 1'b1;
            tick();
            start15 = 1'b0;
            repeat (34) tick();
        end

        repeat (5) tick();
        check("pending8", q8_exp.size(), 0);
        check("pending2", q2_exp.size(), 0);
        check("pending15", q15_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
